// File: rtl/snx_memsys_pkg.sv
// Shared types for the SNX memory/IO responder: FSM states, request kinds and
// the address helper used by the optional range check.
package snx_memsys_pkg;

    localparam int IO_SEL_BIT = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRD,
        S_FHI,
        S_FLO,
        S_FCAP
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_DRD,
        REQ_DWR,
        REQ_FETCH
    } req_e;

    // True when any address bit above the RAM word range (below the IO select) is set.
    function automatic logic hi_bits_set(input logic [14:0] a, input int aw);
        return |(a >> aw);
    endfunction

endpackage

// File: rtl/snx_spram.sv
// Single-port synchronous RAM with one-cycle registered read; contents are not reset.
module snx_spram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/snx_memsys.sv
// SNX core bus memory/IO responder: instruction fetch and data access over one shared
// 16-bit RAM plus a switch/LED port. Define SNX_MEMSYS_RANGE_CHECK_EN for address range errors.
module snx_memsys
    import snx_memsys_pkg::*;
#(
    parameter int AW    = 10,
    parameter int LED_W = 8
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             inst_read,
    input  logic [15:0]      iadrs,
    input  logic             memory_read,
    input  logic             memory_write,
    input  logic [15:0]      adrs,
    input  logic [15:0]      datao,
    input  logic [LED_W-1:0] sw,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic [15:0]      datai,
    output logic             data_done,
    output logic             busy,
    output logic [LED_W-1:0] led,
    output logic             err
);

    state_e           state_q, state_d;
    req_e             req;
    logic             can_acc, is_io, latch_pend;
    logic             pend_q, foor_q, drd_oor_q;
    logic [AW-1:1]    fadr_q, fsel;
    logic [15:0]      hi_q, datai_q;
    logic [31:0]      inst_q;
    logic             inst_valid_q, data_done_q;
    logic [LED_W-1:0] led_q;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [15:0]      ram_rdata, rdata_m;
    logic             d_oor, i_oor, f_oor, rd_mask;
    logic             unused_bits;

`ifdef SNX_MEMSYS_RANGE_CHECK_EN
    logic err_q;

    assign d_oor       = hi_bits_set(adrs[14:0], AW);
    assign i_oor       = hi_bits_set(iadrs[14:0], AW);
    assign unused_bits = iadrs[15];

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            err_q <= 1'b0;
        end else if (((req == REQ_DRD || req == REQ_DWR) && !is_io && d_oor) ||
                     (req == REQ_FETCH && f_oor)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign d_oor       = 1'b0;
    assign i_oor       = 1'b0;
    assign unused_bits = ^{iadrs[15], iadrs[0], adrs[14:0] >> AW, iadrs[14:0] >> AW};
    assign err         = 1'b0;
`endif

    // Request arbitration: a latched fetch outranks new requests; data outranks fetch.
    always_comb begin
        can_acc    = (state_q == S_IDLE) && !data_done_q;
        is_io      = adrs[IO_SEL_BIT];
        fsel       = pend_q ? fadr_q : iadrs[AW-1:1];
        f_oor      = pend_q ? foor_q : i_oor;
        req        = REQ_NONE;
        if (can_acc) begin
            if (pend_q)            req = REQ_FETCH;
            else if (memory_write) req = REQ_DWR;
            else if (memory_read)  req = REQ_DRD;
            else if (inst_read)    req = REQ_FETCH;
        end
        latch_pend = can_acc && !pend_q && (memory_write || memory_read) && inst_read;
        rd_mask    = (state_q == S_DRD) ? drd_oor_q : foor_q;
        rdata_m    = rd_mask ? 16'h0000 : ram_rdata;
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req == REQ_DRD && !is_io) state_d = S_DRD;
                else if (req == REQ_FETCH)    state_d = S_FHI;
            end
            S_DRD:   state_d = S_IDLE;
            S_FHI:   state_d = S_FLO;
            S_FLO:   state_d = S_FCAP;
            S_FCAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM port: the high halfword is issued on the accepting edge, the low one from FHI.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = adrs[AW-1:0];
        unique case (state_q)
            S_IDLE: begin
                if (req == REQ_DWR && !is_io) ram_we = !d_oor;
                if (req == REQ_FETCH)         ram_addr = {fsel, 1'b0};
            end
            S_FHI:   ram_addr = {fadr_q, 1'b1};
            default: ram_addr = adrs[AW-1:0];
        endcase
    end

    assign busy = (state_q != S_IDLE) || data_done_q || pend_q;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            pend_q       <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            datai_q      <= '0;
            data_done_q  <= 1'b0;
            led_q        <= '0;
        end else begin
            data_done_q  <= (state_q == S_DRD) || (req == REQ_DWR) || (req == REQ_DRD && is_io);
            inst_valid_q <= (state_q == S_FLO);
            if (req == REQ_DWR && is_io) led_q <= datao[LED_W-1:0];
            if (req == REQ_DRD && is_io) datai_q <= {{(16-LED_W){1'b0}}, sw};
            if (state_q == S_DRD)        datai_q <= rdata_m;
            if (state_q == S_FLO)        inst_q <= {hi_q, rdata_m};
            if (latch_pend)              pend_q <= 1'b1;
            else if (req == REQ_FETCH)   pend_q <= 1'b0;
        end
    end

    always_ff @(posedge m_clock) begin
        if (req == REQ_DRD) drd_oor_q <= d_oor;
        if (state_q == S_FHI) hi_q <= rdata_m;
        if (latch_pend || (req == REQ_FETCH && !pend_q)) begin
            fadr_q <= iadrs[AW-1:1];
            foor_q <= i_oor;
        end
    end

    snx_spram #(.AW(AW), .DW(16)) u_ram (
        .clk_i   (m_clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (datao),
        .rdata_o (ram_rdata)
    );

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign datai      = datai_q;
    assign data_done  = data_done_q;
    assign led        = led_q;

endmodule

// File: tb/tb_snx_memsys.sv
// Directed testbench for snx_memsys: data/IO access, fetch, arbitration, reset and range handling.
module tb_snx_memsys;

    localparam int AW    = 10;
    localparam int LED_W = 8;

    logic             m_clock, p_reset, inst_read, memory_read, memory_write;
    logic [15:0]      iadrs, adrs, datao, datai;
    logic [LED_W-1:0] sw, led;
    logic [31:0]      inst;
    logic             inst_valid, data_done, busy, err;
    int               vectors, miscompares;

    snx_memsys #(.AW(AW), .LED_W(LED_W)) dut (
        .m_clock      (m_clock),
        .p_reset      (p_reset),
        .inst_read    (inst_read),
        .iadrs        (iadrs),
        .memory_read  (memory_read),
        .memory_write (memory_write),
        .adrs         (adrs),
        .datao        (datao),
        .sw           (sw),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .datai        (datai),
        .data_done    (data_done),
        .busy         (busy),
        .led          (led),
        .err          (err)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic cyc();
        @(negedge m_clock);
    endtask

    task automatic clear_req();
        inst_read = 1'b0; memory_read = 1'b0; memory_write = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        adrs = a; datao = d; memory_write = 1'b1;
        cyc(); clear_req(); cyc();
    endtask

    task automatic test_reset();
        p_reset = 1'b1; clear_req();
        iadrs = '0; adrs = '0; datao = '0; sw = '0;
        #3 p_reset = 1'b0;
        #4;
        vectors++; if (inst !== 32'h0)   begin miscompares++; $display("FAIL rst_inst: got %h want %h", inst, 32'h0); end
        vectors++; if (inst_valid !== 0) begin miscompares++; $display("FAIL rst_ivalid: got %b want 0", inst_valid); end
        vectors++; if (datai !== 16'h0)  begin miscompares++; $display("FAIL rst_datai: got %h want 0000", datai); end
        vectors++; if (data_done !== 0)  begin miscompares++; $display("FAIL rst_done: got %b want 0", data_done); end
        vectors++; if (busy !== 0)       begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (led !== '0)       begin miscompares++; $display("FAIL rst_led: got %h want 00", led); end
        vectors++; if (err !== 0)        begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
        cyc(); cyc();
        p_reset = 1'b1;
        cyc();
    endtask

    task automatic test_data_rw();
        adrs = 16'h0005; datao = 16'h1234; memory_write = 1'b1;
        cyc(); clear_req();
        vectors++; if (data_done !== 1) begin miscompares++; $display("FAIL wr_done_c1: got %b want 1", data_done); end
        vectors++; if (busy !== 1)      begin miscompares++; $display("FAIL wr_busy_c1: got %b want 1", busy); end
        cyc();
        vectors++; if (data_done !== 0) begin miscompares++; $display("FAIL wr_done_c2: got %b want 0", data_done); end
        vectors++; if (busy !== 0)      begin miscompares++; $display("FAIL wr_busy_c2: got %b want 0", busy); end
        adrs = 16'h0005; memory_read = 1'b1;
        cyc(); clear_req();
        vectors++; if (data_done !== 0) begin miscompares++; $display("FAIL rd_done_c1: got %b want 0", data_done); end
        vectors++; if (busy !== 1)      begin miscompares++; $display("FAIL rd_busy_c1: got %b want 1", busy); end
        cyc();
        vectors++; if (data_done !== 1)     begin miscompares++; $display("FAIL rd_done_c2: got %b want 1", data_done); end
        vectors++; if (datai !== 16'h1234)  begin miscompares++; $display("FAIL rd_data: got %h want 1234", datai); end
        cyc();
        vectors++; if (data_done !== 0) begin miscompares++; $display("FAIL rd_done_c3: got %b want 0", data_done); end
    endtask

    task automatic test_fetch();
        logic [15:0] fa [3];
        logic [31:0] fe [3];
        fa[0] = 16'h0011; fe[0] = 32'hA1B2C3D4;
        fa[1] = 16'h0010; fe[1] = 32'hA1B2C3D4;
        fa[2] = 16'h0020; fe[2] = 32'h0F0F7777;
        bus_write(16'h0010, 16'hA1B2);
        bus_write(16'h0011, 16'hC3D4);
        bus_write(16'h0020, 16'h0F0F);
        bus_write(16'h0021, 16'h7777);
        for (int k = 0; k < 3; k++) begin
            iadrs = fa[k]; inst_read = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c == 1) clear_req();
                vectors++;
                if (inst_valid !== (c == 3)) begin
                    miscompares++; $display("FAIL fetch%0d_valid_c%0d: got %b want %b", k, c, inst_valid, (c == 3));
                end
                if (c == 1) begin
                    vectors++; if (busy !== 1) begin miscompares++; $display("FAIL fetch%0d_busy: got %b want 1", k, busy); end
                end
                if (c >= 3) begin
                    vectors++;
                    if (inst !== fe[k]) begin miscompares++; $display("FAIL fetch%0d_inst_c%0d: got %h want %h", k, c, inst, fe[k]); end
                end
                if (c == 4) begin
                    vectors++; if (busy !== 0) begin miscompares++; $display("FAIL fetch%0d_idle: got %b want 0", k, busy); end
                end
            end
        end
    endtask

    task automatic test_io();
        sw = 8'h34; adrs = 16'h8000; memory_read = 1'b1;
        cyc(); clear_req();
        vectors++; if (data_done !== 1)    begin miscompares++; $display("FAIL io_rd_done: got %b want 1", data_done); end
        vectors++; if (datai !== 16'h0034) begin miscompares++; $display("FAIL io_rd_data: got %h want 0034", datai); end
        cyc();
        vectors++; if (data_done !== 0)    begin miscompares++; $display("FAIL io_rd_done_c2: got %b want 0", data_done); end
        adrs = 16'h8000; datao = 16'hFF5A; memory_write = 1'b1;
        cyc(); clear_req();
        vectors++; if (data_done !== 1) begin miscompares++; $display("FAIL io_wr_done: got %b want 1", data_done); end
        vectors++; if (led !== 8'h5A)   begin miscompares++; $display("FAIL io_led: got %h want 5a", led); end
        cyc();
    endtask

    task automatic test_back_to_back();
        // cycles 1..7 after the shared acceptance edge
        logic ed [1:7];
        logic ev [1:7];
        logic eb [1:7];
        ed = '{0, 1, 0, 0, 0, 0, 0};
        ev = '{0, 0, 0, 0, 0, 1, 0};
        eb = '{1, 1, 1, 1, 1, 1, 0};
        adrs = 16'h0005; memory_read = 1'b1; iadrs = 16'h0010; inst_read = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) clear_req();
            vectors++; if (data_done !== ed[c]) begin miscompares++; $display("FAIL b2b_done_c%0d: got %b want %b", c, data_done, ed[c]); end
            vectors++; if (inst_valid !== ev[c]) begin miscompares++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, inst_valid, ev[c]); end
            vectors++; if (busy !== eb[c]) begin miscompares++; $display("FAIL b2b_busy_c%0d: got %b want %b", c, busy, eb[c]); end
            if (c == 2) begin
                vectors++; if (datai !== 16'h1234) begin miscompares++; $display("FAIL b2b_datai: got %h want 1234", datai); end
            end
            if (c == 6) begin
                vectors++; if (inst !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL b2b_inst: got %h want a1b2c3d4", inst); end
            end
        end
    endtask

    task automatic test_reset_midfetch();
        iadrs = 16'h0020; inst_read = 1'b1;
        cyc(); clear_req();
        cyc();
        #2 p_reset = 1'b0;
        #1;
        vectors++; if (inst !== 32'h0)   begin miscompares++; $display("FAIL mrst_inst: got %h want 0", inst); end
        vectors++; if (inst_valid !== 0) begin miscompares++; $display("FAIL mrst_valid: got %b want 0", inst_valid); end
        vectors++; if (busy !== 0)       begin miscompares++; $display("FAIL mrst_busy: got %b want 0", busy); end
        vectors++; if (led !== '0)       begin miscompares++; $display("FAIL mrst_led: got %h want 00", led); end
        vectors++; if (datai !== 16'h0)  begin miscompares++; $display("FAIL mrst_datai: got %h want 0000", datai); end
        cyc(); cyc();
        p_reset = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            vectors++; if (inst_valid !== 0) begin miscompares++; $display("FAIL mrst_novalid_c%0d: got %b want 0", c, inst_valid); end
        end
        iadrs = 16'h0021; inst_read = 1'b1;
        cyc(); clear_req();
        cyc(); cyc();
        vectors++; if (inst_valid !== 1)     begin miscompares++; $display("FAIL mrst_refetch_valid: got %b want 1", inst_valid); end
        vectors++; if (inst !== 32'h0F0F7777) begin miscompares++; $display("FAIL mrst_refetch_inst: got %h want 0f0f7777", inst); end
        cyc();
    endtask

    task automatic test_range();
        logic        exp_err;
        logic [15:0] exp_mem5;
`ifdef SNX_MEMSYS_RANGE_CHECK_EN
        exp_err = 1'b1; exp_mem5 = 16'h1234;
`else
        exp_err = 1'b0; exp_mem5 = 16'hBEEF;
`endif
        adrs = 16'h0405; datao = 16'hBEEF; memory_write = 1'b1;
        cyc(); clear_req();
        vectors++; if (data_done !== 1)   begin miscompares++; $display("FAIL rng_done: got %b want 1", data_done); end
        vectors++; if (err !== exp_err)   begin miscompares++; $display("FAIL rng_err: got %b want %b", err, exp_err); end
        cyc();
        adrs = 16'h0005; memory_read = 1'b1;
        cyc(); clear_req(); cyc();
        vectors++; if (datai !== exp_mem5) begin miscompares++; $display("FAIL rng_mem5: got %h want %h", datai, exp_mem5); end
        vectors++; if (err !== exp_err)    begin miscompares++; $display("FAIL rng_err_sticky: got %b want %b", err, exp_err); end
        cyc();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        test_reset();
        test_data_rw();
        test_fetch();
        test_io();
        test_back_to_back();
        test_reset_midfetch();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
